alu_issue_pipe: RTL and testbench
=================================

Name: alu_issue_pipe

Overview:
- Operand-fetch and writeback stage wrapped around the existing combinational 16-bit ALU.
- Accepts register-addressed ALU instructions over a valid/ready handshake and reads operands from an internal 16-entry register file.
- Drives the ALU inputs from an EX register, then captures the ALU result and flags into a WB register.
- Writes the result back to the register file and presents it downstream over a valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width; must match the ALU operand width.
- ADDR_W, 4, register address width; the file has 2^ADDR_W entries.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid & in_ready at a rising edge
- in_ctrl  in  4  ALU op code, passed through unmodified
- in_rd  in  ADDR_W  destination register
- in_rs  in  ADDR_W  source register for the ALU a operand
- in_rt  in  ADDR_W  source register for the ALU b operand
- init_we  in  1  register preload write enable
- init_addr  in  ADDR_W  preload address
- init_data  in  WIDTH  preload data
- alu_ctrl  out  4  to ALU ctrl
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_s  in  WIDTH  from ALU s
- alu_zero  in  1  from ALU zero
- alu_overflow  in  1  from ALU overflow
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- res_data  out  WIDTH  result value
- res_rd  out  ADDR_W  result destination register
- zero_flag  out  1  sticky copy of the last captured alu_zero
- ovf_flag  out  1  sticky copy of the last captured alu_overflow

Behaviour:
- Reset (clk, rst synchronous active-high):
  - All register-file entries = 0; ex_valid = 0; res_valid = 0.
  - res_data, res_rd, zero_flag, ovf_flag, alu_ctrl, alu_a, alu_b = 0.
  - in_ready = 1 in the first cycle after reset.
  - rst mid-operation discards the in-flight EX and WB contents; no register-file write occurs on the reset edge.
- Register file:
  - r0 always reads 0; writes to r0 are dropped.
  - Reads are combinational and sampled at the accept edge.
  - A same-edge write is not visible to that read; forwarding handles the EX case.
- Stage advance:
  - wb_free = !res_valid | res_ready.
  - ex_adv = ex_valid & wb_free.
  - in_ready = (!ex_valid | ex_adv) & !hazard_stall. hazard_stall is 0 when FWD_EN is defined.
- Accept edge (in_valid & in_ready):
  - EX captures ctrl, rd, and operands a, b; ex_valid <= 1.
  - If not accepting while ex_adv, ex_valid <= 0.
  - alu_ctrl/alu_a/alu_b are driven directly from the EX register, so the ALU evaluates in the cycle after accept.
- ex_adv edge:
  - res_data <= alu_s; res_rd <= ex_rd; zero_flag <= alu_zero; ovf_flag <= alu_overflow; res_valid <= 1.
  - regfile[ex_rd] <= alu_s, unless ex_rd = 0.
- Result handshake:
  - If res_ready and no ex_adv, res_valid <= 0.
  - While res_valid & !res_ready: res_data and res_rd are held stable, EX is frozen, and in_ready = 0.
- Latency and throughput: accept at edge N; res_valid high after edge N+1; throughput 1 instruction per cycle with no backpressure.
- Init port vs writeback: when both target the same register on the same edge, the writeback wins.
- Flags:
  - Update only on ex_adv edges; held otherwise.
  - zero_flag is sticky across idle cycles.
  - Flags update even when rd = 0.
- Ordering: results retire strictly in acceptance order; no instruction is dropped or duplicated under any backpressure pattern.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined (forwarding on):
  - At accept, if ex_valid & rs == ex_rd & ex_rd != 0, operand a = alu_s; same rule for rt / operand b.
  - The forward applies whether or not EX advances on that edge.
  - hazard_stall = 0.
- Undefined (no forwarding): hazard_stall = ex_valid & ex_rd != 0 & (in_rs == ex_rd | in_rt == ex_rd). The dependent instruction waits until its producer has written back, costing at least one bubble.

Test Plan:
- rst held 2 cycles, then released → res_valid = 0, in_ready = 1, zero_flag = 0, ovf_flag = 0; an r1 read via add r2 = r1 + r0 yields 0.
- Preload r1 = 0x0005, r2 = 0x0003; issue ctrl = 1, rd = 3, rs = 1, rt = 2 with res_ready = 1 → cycle after accept: alu_a = 5, alu_b = 3; next cycle: res_valid = 1, res_data = 0x0008, res_rd = 3, zero_flag = 0.
- Back-to-back: add r3 = r1 + r2, then ctrl = 0, rd = 4, rs = 3, rt = 3 → with ALU_ISSUE_FWD_EN: second alu_a = alu_b = 0x0008 with no bubble, res_data = 0, zero_flag = 1; without it: in_ready = 0 for exactly 1 cycle, identical results.
- Three independent adds with res_ready = 0 for 4 cycles → in_ready drops once EX and WB are full; res_data stays 0x0008 throughout; after release, all three results retire in order.
- ctrl = 1, rd = 0, rs = 1, rt = 2 → res_data = 0x0008, res_rd = 0; a later read of r0 gives 0.
- Preload r5 = 0x7FFF, r6 = 0x0001; ctrl = 1, rd = 7 → res_data = 0x8000, ovf_flag = 1; assert rst while a following instruction sits in EX → no r7 write from it, res_valid = 0.

Source files
------------

// File: rtl/alu_issue_pipe.sv
// Operand-fetch / writeback stage around the combinational 16-bit ALU.
// Define ALU_ISSUE_FWD_EN to forward the EX result to a dependent issue instead of stalling.
module alu_issue_pipe #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_ctrl,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [WIDTH-1:0]  init_data,
  output logic [3:0]        alu_ctrl,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_s,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_data,
  output logic [ADDR_W-1:0] res_rd,
  output logic              zero_flag,
  output logic              ovf_flag
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic              wb_free;
  logic              ex_adv;
  logic              accept;
  logic              hazard_stall;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;

  assign wb_free  = !res_valid || res_ready;
  assign ex_adv   = ex_valid && wb_free;
  assign in_ready = (!ex_valid || ex_adv) && !hazard_stall;
  assign accept   = in_valid && in_ready;

  // Operand read; the EX result bypasses the file when it has not been written yet
  always_comb begin
    op_a = (in_rs == '0) ? '0 : regs[in_rs];
    op_b = (in_rt == '0) ? '0 : regs[in_rt];
`ifdef ALU_ISSUE_FWD_EN
    hazard_stall = 1'b0;
    if (ex_valid && ex_rd != '0 && in_rs == ex_rd)
      op_a = alu_s;
    if (ex_valid && ex_rd != '0 && in_rt == ex_rd)
      op_b = alu_s;
`else
    hazard_stall = ex_valid && (ex_rd != '0) && ((in_rs == ex_rd) || (in_rt == ex_rd));
`endif
  end

  // Writeback is ordered after the preload so it wins a same-register collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (init_we && init_addr != '0)
        regs[init_addr] <= init_data;
      if (ex_adv && ex_rd != '0)
        regs[ex_rd] <= alu_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      alu_ctrl <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_rd    <= in_rd;
      alu_ctrl <= in_ctrl;
      alu_a    <= op_a;
      alu_b    <= op_b;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  // Flags share the result's capture edge, so they stay sticky while the stage idles
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else if (ex_adv) begin
      res_valid <= 1'b1;
      res_data  <= alu_s;
      res_rd    <= ex_rd;
      zero_flag <= alu_zero;
      ovf_flag  <= alu_overflow;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Scoreboard bench for alu_issue_pipe with a behavioural stand-in for the 16-bit ALU.
// Build with or without ALU_ISSUE_FWD_EN; only the hazard bubble count differs.
module tb_alu_issue_pipe;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  rd;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs;
  logic [3:0]  in_rt;
  logic        init_we;
  logic [3:0]  init_addr;
  logic [15:0] init_data;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_s;
  logic        alu_zero;
  logic        alu_overflow;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_rd;
  logic        zero_flag;
  logic        ovf_flag;

  int          tests_run;
  int          tests_failed;
  logic        random_bp;
  exp_t        exp_q[$];
  logic [15:0] ref_regs [16];

  alu_issue_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_s(alu_s), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd),
    .zero_flag(zero_flag), .ovf_flag(ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU op codes: 0 sub, 1 add, 2 and, 3 or, others xor; returns {ovf, zero, s}
  function automatic logic [17:0] alu_fn(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic        v;
    v = 1'b0;
    case (c)
      4'd0: begin s = a - b; v = (a[15] != b[15]) && (s[15] != a[15]); end
      4'd1: begin s = a + b; v = (a[15] == b[15]) && (s[15] != a[15]); end
      4'd2: s = a & b;
      4'd3: s = a | b;
      default: s = a ^ b;
    endcase
    return {v, (s == 16'd0), s};
  endfunction

  always_comb {alu_overflow, alu_zero, alu_s} = alu_fn(alu_ctrl, alu_a, alu_b);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++)
      ref_regs[i] = 16'd0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the instruction
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [3:0] rd, input logic [3:0] rs,
                               input logic [3:0] rt, output int waits);
    logic [15:0] a;
    logic [15:0] b;
    logic [17:0] r;
    exp_t        e;
    in_valid = 1'b1;
    in_ctrl  = ctrl;
    in_rd    = rd;
    in_rs    = rs;
    in_rt    = rt;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 64) begin
      nextCycle();
      if (random_bp) res_ready = 1'($urandom_range(0, 1));
      waits++;
      @(negedge clk);
    end
    checkOutput("issue_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      a = (rs == 4'd0) ? 16'd0 : ref_regs[rs];
      b = (rt == 4'd0) ? 16'd0 : ref_regs[rt];
      r = alu_fn(ctrl, a, b);
      e.data = r[15:0];
      e.rd   = rd;
      e.zero = r[16];
      e.ovf  = r[17];
      exp_q.push_back(e);
      if (rd != 4'd0) ref_regs[rd] = r[15:0];
    end
    nextCycle();
    in_valid = 1'b0;
    if (random_bp) res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic initWrite(input logic [3:0] addr, input logic [15:0] data);
    init_we   = 1'b1;
    init_addr = addr;
    init_data = data;
    nextCycle();
    init_we = 1'b0;
    if (addr != 4'd0) ref_regs[addr] = data;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic watchResults();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_data", 32'(res_data), 32'(e.data));
          checkOutput("res_rd", 32'(res_rd), 32'(e.rd));
          checkOutput("zero_flag", 32'(zero_flag), 32'(e.zero));
          checkOutput("ovf_flag", 32'(ovf_flag), 32'(e.ovf));
        end
      end
    end
  endtask

  initial begin
    int w;
    int exp_bubble;
    tests_run    = 0;
    tests_failed = 0;
    random_bp    = 1'b0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_ctrl      = 4'd0;
    in_rd        = 4'd0;
    in_rs        = 4'd0;
    in_rt        = 4'd0;
    init_we      = 1'b0;
    init_addr    = 4'd0;
    init_data    = 16'd0;
    res_ready    = 1'b1;
    clearModel();
`ifdef ALU_ISSUE_FWD_EN
    exp_bubble = 0;
`else
    exp_bubble = 1;
`endif
    fork
      watchResults();
      begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_zero_flag", 32'(zero_flag), 32'd0);
    checkOutput("rst_ovf_flag", 32'(ovf_flag), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    nextCycle();
    applyStimulus(4'd1, 4'd2, 4'd1, 4'd0, w);
    drain();

    // Basic add with exact operand and result timing
    initWrite(4'd1, 16'h0005);
    initWrite(4'd2, 16'h0003);
    applyStimulus(4'd1, 4'd3, 4'd1, 4'd2, w);
    @(negedge clk);
    checkOutput("ex_alu_a", 32'(alu_a), 32'h5);
    checkOutput("ex_alu_b", 32'(alu_b), 32'h3);
    @(negedge clk);
    checkOutput("wb_res_valid", 32'(res_valid), 32'd1);
    checkOutput("wb_res_data", 32'(res_data), 32'h8);
    checkOutput("wb_res_rd", 32'(res_rd), 32'd3);
    nextCycle();
    drain();

    // Dependent back-to-back pair
    applyStimulus(4'd1, 4'd3, 4'd1, 4'd2, w);
    applyStimulus(4'd0, 4'd4, 4'd3, 4'd3, w);
    checkOutput("hazard_bubbles", 32'(w), 32'(exp_bubble));
    @(negedge clk);
    checkOutput("dep_alu_a", 32'(alu_a), 32'h8);
    checkOutput("dep_alu_b", 32'(alu_b), 32'h8);
    nextCycle();
    drain();
    repeat (3) nextCycle();
    checkOutput("zero_sticky", 32'(zero_flag), 32'd1);

    // Backpressure: EX and WB fill, WB holds its value
    res_ready = 1'b0;
    applyStimulus(4'd1, 4'd8, 4'd1, 4'd2, w);
    applyStimulus(4'd1, 4'd9, 4'd1, 4'd1, w);
    in_valid = 1'b1;
    in_ctrl  = 4'd1;
    in_rd    = 4'd10;
    in_rs    = 4'd2;
    in_rt    = 4'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_res_data", 32'(res_data), 32'h8);
      checkOutput("bp_res_valid", 32'(res_valid), 32'd1);
    end
    nextCycle();
    res_ready = 1'b1;
    applyStimulus(4'd1, 4'd10, 4'd2, 4'd2, w);
    drain();

    // r0 destination and r0 source
    applyStimulus(4'd1, 4'd0, 4'd1, 4'd2, w);
    drain();
    initWrite(4'd0, 16'h1234);
    applyStimulus(4'd1, 4'd11, 4'd0, 4'd1, w);
    drain();

    // Writeback beats a preload of the same register on the same edge
    applyStimulus(4'd1, 4'd12, 4'd1, 4'd2, w);
    init_we   = 1'b1;
    init_addr = 4'd12;
    init_data = 16'hDEAD;
    nextCycle();
    init_we = 1'b0;
    drain();
    applyStimulus(4'd1, 4'd13, 4'd12, 4'd0, w);
    drain();

    // Signed overflow, then reset with an instruction parked in EX
    initWrite(4'd5, 16'h7FFF);
    initWrite(4'd6, 16'h0001);
    applyStimulus(4'd1, 4'd7, 4'd5, 4'd6, w);
    drain();
    checkOutput("ovf_sticky", 32'(ovf_flag), 32'd1);
    applyStimulus(4'd1, 4'd7, 4'd1, 4'd1, w);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    exp_q.delete();
    clearModel();
    @(negedge clk);
    checkOutput("mid_rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_ovf_flag", 32'(ovf_flag), 32'd0);
    nextCycle();
    applyStimulus(4'd1, 4'd8, 4'd7, 4'd0, w);
    applyStimulus(4'd1, 4'd9, 4'd5, 4'd6, w);
    drain();

    // Random mix with random downstream backpressure
    for (int i = 1; i < 8; i++)
      initWrite(4'(i), 16'($urandom));
    random_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(4'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), w);
      if ($urandom_range(0, 3) == 0) begin
        nextCycle();
        res_ready = 1'($urandom_range(0, 1));
      end
    end
    random_bp = 1'b0;
    res_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
